fetch_arbiter: RTL and testbench

Parametrised successor to the single-shot instruction-fetch queue. It arbitrates N fetch ports onto M memory read ports with valid/ready handshakes and round-robin fairness. Each memory port may have up to MAX_OUTSTANDING requests in flight, and responses are tracked through a per-port in-order tag FIFO. A per-fetch-port flush squashes in-flight responses, so a killed parallel branch never sees stale instructions. It sits between the per-branch fetch stages and the instruction memory interface.

---
 rtl/fetch_arbiter_pkg.sv | 13 +
 rtl/fetch_arbiter_if.sv | 38 +++
 rtl/fetch_tag_fifo.sv | 61 ++++++
 rtl/fetch_arbiter.sv | 137 +++++++++++++
 tb/tb_fetch_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_arbiter_pkg.sv
// Shared types for the fetch arbiter: the in-flight tag carried through each
// memory port's tag FIFO, plus the fixed instruction request size.
package fetch_arbiter_pkg;

    localparam int INST_BYTES  = 4;
    localparam int FETCH_IDX_W = 8;

    typedef struct packed {
        logic [FETCH_IDX_W-1:0] fetch_idx;
        logic                   squashed;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_arbiter_if.sv
// Fetch-side and memory-side handshake bundle of the fetch arbiter.
// The arbiter sits on the slave modport; fetch stages and memory on master.
interface fetch_arbiter_if #(
    parameter int FETCH_PORT_CNT = 4,
    parameter int MEM_PORT_CNT   = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
);
    logic [FETCH_PORT_CNT-1:0]             fetch_req_valid;
    logic [FETCH_PORT_CNT-1:0][ADDR_W-1:0] fetch_req_pc;
    logic [FETCH_PORT_CNT-1:0]             fetch_req_ready;
    logic [FETCH_PORT_CNT-1:0]             fetch_flush;
    logic [FETCH_PORT_CNT-1:0]             fetch_rsp_valid;
    logic [FETCH_PORT_CNT-1:0][DATA_W-1:0] fetch_rsp_inst;
    logic [FETCH_PORT_CNT-1:0]             fetch_rsp_err;
    logic [MEM_PORT_CNT-1:0]               mem_req_valid;
    logic [MEM_PORT_CNT-1:0][ADDR_W-1:0]   mem_req_addr;
    logic [MEM_PORT_CNT-1:0]               mem_req_ready;
    logic [MEM_PORT_CNT-1:0]               mem_rsp_valid;
    logic [MEM_PORT_CNT-1:0][DATA_W-1:0]   mem_rsp_data;
    logic [MEM_PORT_CNT-1:0]               mem_rsp_err;
    logic                                  protocol_err;

    modport slave (
        input  fetch_req_valid, fetch_req_pc, fetch_flush,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_inst, fetch_rsp_err,
        output mem_req_valid, mem_req_addr, protocol_err
    );

    modport master (
        output fetch_req_valid, fetch_req_pc, fetch_flush,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_inst, fetch_rsp_err,
        input  mem_req_valid, mem_req_addr, protocol_err
    );

endinterface

// File: rtl/fetch_tag_fifo.sv
// In-order tag FIFO for one memory port. A flush mask marks every stored
// entry belonging to a flushed fetch port as squashed.
module fetch_tag_fifo
    import fetch_arbiter_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int FLUSH_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_tag_t         push_tag,
    input  logic               pop,
    input  logic [FLUSH_W-1:0] flush,
    output fetch_tag_t         head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_tag_t       entry [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = entry[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) entry[k] <= '0;
        end else begin
            // Stale slots may get marked too; they are overwritten on the next push.
            for (int k = 0; k < DEPTH; k++)
                for (int f = 0; f < FLUSH_W; f++)
                    if (flush[f] && entry[k].fetch_idx == FETCH_IDX_W'(f))
                        entry[k].squashed <= 1'b1;
            if (push) begin
                entry[wr_ptr] <= push_tag;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter of fetch ports onto memory read ports, with per-port
// busy tracking, squash-on-flush and registered one-cycle response pulses.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int FETCH_PORT_CNT  = 4,
    parameter int MEM_PORT_CNT    = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input logic            clk,
    input logic            rst_n,
    fetch_arbiter_if.slave bus
);

    localparam int HEAD_W = $clog2(FETCH_PORT_CNT);

    logic [FETCH_PORT_CNT-1:0]             busy;
    logic [FETCH_PORT_CNT-1:0]             eligible;
    logic [FETCH_PORT_CNT-1:0]             grant_ready;
    logic [FETCH_PORT_CNT-1:0]             busy_clr;
    logic [FETCH_PORT_CNT-1:0]             rsp_valid_q, rsp_valid_d;
    logic [FETCH_PORT_CNT-1:0][DATA_W-1:0] rsp_inst_q, rsp_inst_d;
    logic [FETCH_PORT_CNT-1:0]             rsp_err_q, rsp_err_d;
    logic [HEAD_W-1:0]                     rr_head, rr_head_d;
    logic [MEM_PORT_CNT-1:0]               avail, grant_valid;
    logic [MEM_PORT_CNT-1:0]               fifo_full, fifo_empty, fifo_pop;
    logic [MEM_PORT_CNT-1:0][ADDR_W-1:0]   grant_addr;
    fetch_tag_t                            fifo_head [MEM_PORT_CNT];
    fetch_tag_t                            push_tag  [MEM_PORT_CNT];
    logic                                  protocol_err_q;
    logic                                  proto_hit;

    // Gating with rst_n keeps the combinational grant outputs at 0 while in reset.
    assign eligible = bus.fetch_req_valid & ~busy & ~bus.fetch_flush & {FETCH_PORT_CNT{rst_n}};
    assign fifo_pop = bus.mem_rsp_valid & ~fifo_empty;
    // A full FIFO popping this cycle has room; only the pop strobe reaches the grant path.
    assign avail     = bus.mem_req_ready & (~fifo_full | fifo_pop);
    assign proto_hit = |(bus.mem_rsp_valid & fifo_empty);

    always_comb begin
        logic [HEAD_W-1:0] idx;
        logic              placed;
        int                next_mem;
        idx         = '0;
        placed      = 1'b0;
        next_mem    = 0;
        grant_ready = '0;
        grant_valid = '0;
        grant_addr  = '0;
        rr_head_d   = rr_head;
        for (int j = 0; j < MEM_PORT_CNT; j++) push_tag[j] = '0;
        for (int k = 0; k < FETCH_PORT_CNT; k++) begin
            idx    = rr_head + HEAD_W'(k);
            placed = 1'b0;
            if (eligible[idx]) begin
                for (int j = 0; j < MEM_PORT_CNT; j++) begin
                    if (!placed && j >= next_mem && avail[j]) begin
                        placed                = 1'b1;
                        next_mem              = j + 1;
                        grant_valid[j]        = 1'b1;
                        grant_addr[j]         = bus.fetch_req_pc[idx];
                        push_tag[j].fetch_idx = FETCH_IDX_W'(idx);
                        grant_ready[idx]      = 1'b1;
                        rr_head_d             = idx + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_inst_d  = rsp_inst_q;
        rsp_err_d   = rsp_err_q;
        busy_clr    = '0;
        for (int j = 0; j < MEM_PORT_CNT; j++) begin
            if (fifo_pop[j]) begin
                for (int i = 0; i < FETCH_PORT_CNT; i++) begin
                    if (fifo_head[j].fetch_idx == FETCH_IDX_W'(i)) begin
                        busy_clr[i] = 1'b1;
                        if (!fifo_head[j].squashed && !bus.fetch_flush[i]) begin
                            rsp_valid_d[i] = 1'b1;
                            rsp_inst_d[i]  = bus.mem_rsp_data[j];
                            rsp_err_d[i]   = bus.mem_rsp_err[j];
                        end
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < MEM_PORT_CNT; j++) begin : g_fifo
        fetch_tag_fifo #(
            .DEPTH   (MAX_OUTSTANDING),
            .FLUSH_W (FETCH_PORT_CNT)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (grant_valid[j]),
            .push_tag (push_tag[j]),
            .pop      (fifo_pop[j]),
            .flush    (bus.fetch_flush),
            .head     (fifo_head[j]),
            .full     (fifo_full[j]),
            .empty    (fifo_empty[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= '0;
            rr_head        <= '0;
            rsp_valid_q    <= '0;
            rsp_inst_q     <= '0;
            rsp_err_q      <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            busy           <= (busy & ~busy_clr) | grant_ready;
            rr_head        <= rr_head_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_inst_q     <= rsp_inst_d;
            rsp_err_q      <= rsp_err_d;
            protocol_err_q <= protocol_err_q | proto_hit;
        end
    end

    assign bus.fetch_req_ready = grant_ready;
    assign bus.mem_req_valid   = grant_valid;
    assign bus.mem_req_addr    = grant_addr;
    assign bus.fetch_rsp_valid = rsp_valid_q;
    assign bus.fetch_rsp_inst  = rsp_inst_q;
    assign bus.fetch_rsp_err   = rsp_err_q;
    assign bus.protocol_err    = protocol_err_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_fetch_arbiter;

    localparam int F  = 4;
    localparam int M  = 2;
    localparam int D  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    fetch_arbiter_if #(.FETCH_PORT_CNT(F), .MEM_PORT_CNT(M), .ADDR_W(AW), .DATA_W(DW)) bus ();

    fetch_arbiter #(
        .FETCH_PORT_CNT  (F),
        .MEM_PORT_CNT    (M),
        .MAX_OUTSTANDING (D),
        .ADDR_W          (AW),
        .DATA_W          (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pcs();
        for (int i = 0; i < F; i++) bus.fetch_req_pc[i] = 32'h1000 + 32'(4 * i);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.fetch_req_valid = '0;
        bus.fetch_req_pc    = '0;
        bus.fetch_flush     = '0;
        bus.mem_req_ready   = '0;
        bus.mem_rsp_valid   = '0;
        bus.mem_rsp_data    = '0;
        bus.mem_rsp_err     = '0;
        tick();
        tick();
        check("rst_req_ready", 64'(bus.fetch_req_ready), 64'h0);
        check("rst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
        check("rst_rsp_valid", 64'(bus.fetch_rsp_valid), 64'h0);
        check("rst_proto_err", 64'(bus.protocol_err), 64'h0);
        rst_n = 1'b1;

        // Single fetch on port 0, response three cycles later
        bus.mem_req_ready    = 2'b11;
        bus.fetch_req_pc[0]  = 32'h100;
        bus.fetch_req_valid  = 4'b0001;
        #1;
        check("t1_req_ready", 64'(bus.fetch_req_ready), 64'b0001);
        check("t1_mem_valid", 64'(bus.mem_req_valid), 64'b01);
        check("t1_mem_addr0", 64'(bus.mem_req_addr[0]), 64'h100);
        tick();
        bus.fetch_req_valid = '0;
        check("t1_busy_set", 64'(dut.busy), 64'b0001);
        tick();
        tick();
        bus.mem_rsp_valid   = 2'b01;
        bus.mem_rsp_data[0] = 32'h0000_0013;
        #1;
        check("t1_no_early_rsp", 64'(bus.fetch_rsp_valid), 64'h0);
        tick();
        bus.mem_rsp_valid = '0;
        check("t1_rsp_valid", 64'(bus.fetch_rsp_valid), 64'b0001);
        check("t1_rsp_inst0", 64'(bus.fetch_rsp_inst[0]), 64'h13);
        check("t1_rsp_err0", 64'(bus.fetch_rsp_err[0]), 64'h0);
        check("t1_busy_clr", 64'(dut.busy), 64'h0);
        tick();
        check("t1_pulse_1cyc", 64'(bus.fetch_rsp_valid), 64'h0);
        check("t1_inst_hold", 64'(bus.fetch_rsp_inst[0]), 64'h13);

        // Fresh round-robin head for the fairness sequence
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_pcs();

        // All ports request every cycle: {0,1}, {2,3}, {0,1}
        bus.fetch_req_valid = 4'b1111;
        #1;
        check("t2a_ready", 64'(bus.fetch_req_ready), 64'b0011);
        check("t2a_mem_valid", 64'(bus.mem_req_valid), 64'b11);
        check("t2a_addr0", 64'(bus.mem_req_addr[0]), 64'h1000);
        check("t2a_addr1", 64'(bus.mem_req_addr[1]), 64'h1004);
        tick();
        bus.mem_rsp_valid   = 2'b11;
        bus.mem_rsp_data[0] = 32'hA0;
        bus.mem_rsp_data[1] = 32'hA1;
        #1;
        check("t2b_ready", 64'(bus.fetch_req_ready), 64'b1100);
        check("t2b_addr0", 64'(bus.mem_req_addr[0]), 64'h1008);
        check("t2b_addr1", 64'(bus.mem_req_addr[1]), 64'h100C);
        tick();
        bus.mem_rsp_valid = '0;
        check("t2c_rsp_valid", 64'(bus.fetch_rsp_valid), 64'b0011);
        check("t2c_inst0", 64'(bus.fetch_rsp_inst[0]), 64'hA0);
        check("t2c_inst1", 64'(bus.fetch_rsp_inst[1]), 64'hA1);
        #1;
        check("t2c_ready", 64'(bus.fetch_req_ready), 64'b0011);
        check("t2c_addr0", 64'(bus.mem_req_addr[0]), 64'h1000);
        tick();
        bus.fetch_req_valid = '0;
        check("t2_busy_all", 64'(dut.busy), 64'b1111);
        bus.mem_rsp_valid   = 2'b11;
        bus.mem_rsp_data[0] = 32'hB2;
        bus.mem_rsp_data[1] = 32'hB3;
        tick();
        check("t2d_rsp_valid", 64'(bus.fetch_rsp_valid), 64'b1100);
        check("t2d_inst2", 64'(bus.fetch_rsp_inst[2]), 64'hB2);
        check("t2d_inst3", 64'(bus.fetch_rsp_inst[3]), 64'hB3);
        bus.mem_rsp_data[0] = 32'hC0;
        bus.mem_rsp_data[1] = 32'hC1;
        tick();
        bus.mem_rsp_valid = '0;
        check("t2e_rsp_valid", 64'(bus.fetch_rsp_valid), 64'b0011);
        check("t2e_busy_clr", 64'(dut.busy), 64'h0);

        // Memory never responds: each FIFO takes two, then everything stalls
        bus.fetch_req_valid = 4'b1111;
        #1;
        check("t3a_ready", 64'(bus.fetch_req_ready), 64'b1100);
        check("t3a_addr0", 64'(bus.mem_req_addr[0]), 64'h1008);
        check("t3a_addr1", 64'(bus.mem_req_addr[1]), 64'h100C);
        tick();
        #1;
        check("t3b_ready", 64'(bus.fetch_req_ready), 64'b0011);
        check("t3b_mem_valid", 64'(bus.mem_req_valid), 64'b11);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_mem_valid", 64'(bus.mem_req_valid), 64'h0);
            check("t3_stall_ready", 64'(bus.fetch_req_ready), 64'h0);
            tick();
        end
        bus.fetch_req_valid = '0;
        bus.mem_rsp_valid   = 2'b11;
        bus.mem_rsp_data[0] = 32'h22;
        bus.mem_rsp_data[1] = 32'h33;
        tick();
        check("t3_drain1_valid", 64'(bus.fetch_rsp_valid), 64'b1100);
        check("t3_drain1_inst2", 64'(bus.fetch_rsp_inst[2]), 64'h22);
        bus.mem_rsp_data[0] = 32'h10;
        bus.mem_rsp_data[1] = 32'h11;
        tick();
        bus.mem_rsp_valid = '0;
        check("t3_drain2_valid", 64'(bus.fetch_rsp_valid), 64'b0011);
        check("t3_drain2_inst1", 64'(bus.fetch_rsp_inst[1]), 64'h11);

        // Flush port 1 while in flight; its response must be swallowed
        bus.fetch_req_valid = 4'b0010;
        #1;
        check("t4_grant_ready", 64'(bus.fetch_req_ready), 64'b0010);
        check("t4_grant_mem", 64'(bus.mem_req_valid), 64'b01);
        check("t4_grant_addr", 64'(bus.mem_req_addr[0]), 64'h1004);
        tick();
        bus.fetch_flush = 4'b0010;
        #1;
        check("t4_flush_ready", 64'(bus.fetch_req_ready), 64'h0);
        tick();
        bus.fetch_flush = '0;
        check("t4_busy_held", 64'(dut.busy), 64'b0010);
        tick();
        bus.mem_rsp_valid   = 2'b01;
        bus.mem_rsp_data[0] = 32'hDEAD_BEEF;
        #1;
        check("t4_busy_ready", 64'(bus.fetch_req_ready), 64'h0);
        tick();
        bus.mem_rsp_valid = '0;
        check("t4_no_pulse", 64'(bus.fetch_rsp_valid), 64'h0);
        check("t4_inst_kept", 64'(bus.fetch_rsp_inst[1]), 64'h11);
        check("t4_busy_clr", 64'(dut.busy), 64'h0);
        #1;
        check("t4_regrant", 64'(bus.fetch_req_ready), 64'b0010);
        check("t4_regrant_mem", 64'(bus.mem_req_valid), 64'b01);
        tick();
        bus.fetch_req_valid = '0;
        bus.mem_rsp_valid   = 2'b01;
        bus.mem_rsp_data[0] = 32'h55;
        tick();
        bus.mem_rsp_valid = '0;
        check("t4_rsp2_valid", 64'(bus.fetch_rsp_valid), 64'b0010);
        check("t4_rsp2_inst", 64'(bus.fetch_rsp_inst[1]), 64'h55);

        // Flush and response for port 2 in the same cycle; flush blocks port 3's grant
        bus.fetch_req_valid = 4'b0100;
        #1;
        check("t5_grant", 64'(bus.fetch_req_ready), 64'b0100);
        tick();
        check("t5_busy", 64'(dut.busy), 64'b0100);
        bus.fetch_req_valid = 4'b1000;
        bus.fetch_flush     = 4'b1100;
        bus.mem_rsp_valid   = 2'b01;
        bus.mem_rsp_data[0] = 32'h77;
        #1;
        check("t5_flush_blocks", 64'(bus.fetch_req_ready), 64'h0);
        check("t5_flush_mem", 64'(bus.mem_req_valid), 64'h0);
        tick();
        bus.fetch_req_valid = '0;
        bus.fetch_flush     = '0;
        bus.mem_rsp_valid   = '0;
        check("t5_no_pulse", 64'(bus.fetch_rsp_valid), 64'h0);
        check("t5_busy_clr", 64'(dut.busy), 64'h0);
        check("t5_inst_kept", 64'(bus.fetch_rsp_inst[2]), 64'h22);

        // Response on an empty FIFO sets the sticky protocol error
        bus.mem_rsp_valid = 2'b10;
        #1;
        check("t6_perr_before", 64'(bus.protocol_err), 64'h0);
        tick();
        bus.mem_rsp_valid = '0;
        check("t6_perr_set", 64'(bus.protocol_err), 64'h1);
        check("t6_perr_no_pulse", 64'(bus.fetch_rsp_valid), 64'h0);
        tick();
        tick();
        check("t6_perr_sticky", 64'(bus.protocol_err), 64'h1);

        // Asynchronous reset in the middle of a burst
        bus.fetch_req_valid = 4'b1111;
        #1;
        check("t7_burst_a", 64'(bus.fetch_req_ready), 64'b1001);
        check("t7_burst_addr0", 64'(bus.mem_req_addr[0]), 64'h100C);
        tick();
        bus.mem_rsp_valid   = 2'b11;
        bus.mem_rsp_data[0] = 32'h99;
        bus.mem_rsp_data[1] = 32'h98;
        #1;
        check("t7_burst_b", 64'(bus.fetch_req_ready), 64'b0110);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_ready", 64'(bus.fetch_req_ready), 64'h0);
        check("t7_rst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
        check("t7_rst_mem_addr", 64'(bus.mem_req_addr[0]), 64'h0);
        check("t7_rst_rsp_valid", 64'(bus.fetch_rsp_valid), 64'h0);
        check("t7_rst_inst1", 64'(bus.fetch_rsp_inst[1]), 64'h0);
        check("t7_rst_perr", 64'(bus.protocol_err), 64'h0);
        bus.fetch_req_valid = '0;
        bus.mem_rsp_valid   = '0;
        tick();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 2'b11;
        tick();
        bus.mem_rsp_valid = '0;
        check("t7_post_no_pulse", 64'(bus.fetch_rsp_valid), 64'h0);
        check("t7_post_fifo_empty", 64'(bus.protocol_err), 64'h1);
        check("t7_post_busy", 64'(dut.busy), 64'h0);
        tick();
        check("t7_post_no_pulse2", 64'(bus.fetch_rsp_valid), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
